spi_route_ctrl: RTL and testbench

Parametrised successor to the single-target CPLD SPI pass-through. Routes one host SPI port to one of N_CH FPGA targets, chosen by a select bus latched at NSS assertion. Adds a registered NSS qualifier, an activity timeout and a per-channel CRESET pulse generator. Also provides CDONE/INT synchronisation. Sits in the CPLD between the host MCU and the FPGA array.

---
 rtl/spi_route_ctrl_if.sv | 44 ++++
 rtl/spi_route_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_spi_route_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_route_ctrl_if.sv
// spi_route_ctrl_if: host-side and target-side SPI, CRESET, CDONE/INT and
// status signals of the CPLD router, bundled for one port connection.
//   slave  : the router (consumes host/target inputs, drives routed outputs)
//   master : the surrounding host/target environment
interface spi_route_ctrl_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned SEL_W = 2
) ();

  logic              FPGA_SPI_CLK_IN;
  logic              FPGA_SPI_MOSI_IN;
  logic              FPGA_SPI_NSS_IN;
  logic              FPGA_SPI_MISO_OUT;
  logic [SEL_W-1:0]  FPGA_SEL_IN;
  logic [N_CH-1:0]   FPGA_SPI_CLK_OUT;
  logic [N_CH-1:0]   FPGA_SPI_MOSI_OUT;
  logic [N_CH-1:0]   FPGA_SPI_NSS_OUT;
  logic [N_CH-1:0]   FPGA_SPI_MISO_IN;
  logic [N_CH-1:0]   FPGA_SPI_INT_IN;
  logic              FPGA_SPI_INT_OUT;
  logic              FPGA_CRESET_REQ_IN;
  logic [N_CH-1:0]   FPGA_CRESET_OUT;
  logic [N_CH-1:0]   FPGA_CDONE_IN;
  logic [N_CH-1:0]   FPGA_CDONE_OUT;
  logic              FPGA_BUSY_OUT;
  logic              FPGA_TIMEOUT_OUT;

  modport slave (
    input  FPGA_SPI_CLK_IN, FPGA_SPI_MOSI_IN, FPGA_SPI_NSS_IN, FPGA_SEL_IN,
           FPGA_SPI_MISO_IN, FPGA_SPI_INT_IN, FPGA_CRESET_REQ_IN, FPGA_CDONE_IN,
    output FPGA_SPI_MISO_OUT, FPGA_SPI_CLK_OUT, FPGA_SPI_MOSI_OUT, FPGA_SPI_NSS_OUT,
           FPGA_SPI_INT_OUT, FPGA_CRESET_OUT, FPGA_CDONE_OUT, FPGA_BUSY_OUT,
           FPGA_TIMEOUT_OUT
  );

  modport master (
    output FPGA_SPI_CLK_IN, FPGA_SPI_MOSI_IN, FPGA_SPI_NSS_IN, FPGA_SEL_IN,
           FPGA_SPI_MISO_IN, FPGA_SPI_INT_IN, FPGA_CRESET_REQ_IN, FPGA_CDONE_IN,
    input  FPGA_SPI_MISO_OUT, FPGA_SPI_CLK_OUT, FPGA_SPI_MOSI_OUT, FPGA_SPI_NSS_OUT,
           FPGA_SPI_INT_OUT, FPGA_CRESET_OUT, FPGA_CDONE_OUT, FPGA_BUSY_OUT,
           FPGA_TIMEOUT_OUT
  );

endinterface

// File: rtl/spi_route_ctrl.sv
// spi_route_ctrl: routes one host SPI port to one of N_CH FPGA targets.
// The target is chosen by SEL latched when the synchronised NSS goes low;
// routing opens after SETUP_CYC cycles, closes on NSS release or on the
// activity timeout. Also generates per-channel CRESET pulses on host request
// and synchronises CDONE/INT.
// Ports:
//   SYS_CLK_IN  system clock
//   SYS_RST_IN  asynchronous reset, active-high
//   bus         spi_route_ctrl_if.slave (host SPI, per-target SPI, CRESET,
//               CDONE, INT, BUSY and TIMEOUT status)
module spi_route_ctrl #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned CRESET_CYC  = 200,
  parameter int unsigned CNT_W       = 16
) (
  input logic             SYS_CLK_IN,
  input logic             SYS_RST_IN,
  spi_route_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_ACTIVE,
    ST_REJECT,
    ST_TOUT
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  crst_cnt_q, crst_cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [N_CH-1:0]   creset_q, creset_d;
  logic [N_CH-1:0]   nss_out_q, nss_out_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;

  // Two-flop synchronisers plus the REQ edge detector history.
  logic              nss_m_q, nss_s_q;
  logic              req_m_q, req_s_q, req_prev_q;
  logic [N_CH-1:0]   int_m_q, int_s_q;
  logic [N_CH-1:0]   cdone_m_q, cdone_s_q;

  logic              sel_in_valid_c;
  logic              crst_run_c;
  logic              req_rise_c;
  logic [N_CH-1:0]   route_hot_c;

  assign sel_in_valid_c = (32'(bus.FPGA_SEL_IN) < N_CH);
  // A pulse is running whenever any CRESET line is held low.
  assign crst_run_c     = (creset_q != '1);
  assign req_rise_c     = req_s_q & ~req_prev_q;

  // State, counters and registered outputs.
  always_ff @(posedge SYS_CLK_IN or posedge SYS_RST_IN) begin
    if (SYS_RST_IN) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      crst_cnt_q <= '0;
      sel_q      <= '0;
      creset_q   <= '1;
      nss_out_q  <= '1;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      nss_m_q    <= 1'b1;
      nss_s_q    <= 1'b1;
      req_m_q    <= 1'b0;
      req_s_q    <= 1'b0;
      req_prev_q <= 1'b0;
      int_m_q    <= '0;
      int_s_q    <= '0;
      cdone_m_q  <= '0;
      cdone_s_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crst_cnt_q <= crst_cnt_d;
      sel_q      <= sel_d;
      creset_q   <= creset_d;
      nss_out_q  <= nss_out_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      nss_m_q    <= bus.FPGA_SPI_NSS_IN;
      nss_s_q    <= nss_m_q;
      req_m_q    <= bus.FPGA_CRESET_REQ_IN;
      req_s_q    <= req_m_q;
      req_prev_q <= req_s_q;
      int_m_q    <= bus.FPGA_SPI_INT_IN;
      int_s_q    <= int_m_q;
      cdone_m_q  <= bus.FPGA_CDONE_IN;
      cdone_s_q  <= cdone_m_q;
    end
  end

  // Next-state: CRESET pulse generator and routing FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crst_cnt_d = crst_cnt_q;
    sel_d      = sel_q;
    creset_d   = creset_q;
    timeout_d  = timeout_q;

    // Requests are only honoured from a quiet IDLE; anything else is dropped.
    if (crst_run_c) begin
      if (crst_cnt_q == CNT_W'(CRESET_CYC - 1)) begin
        creset_d   = '1;
        crst_cnt_d = '0;
      end else begin
        crst_cnt_d = crst_cnt_q + CNT_W'(1);
      end
    end else if ((state_q == ST_IDLE) && nss_s_q && req_rise_c && sel_in_valid_c) begin
      creset_d   = ~(N_CH'(1) << bus.FPGA_SEL_IN);
      crst_cnt_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        // NSS assertion waits for a running CRESET pulse to finish.
        if (!nss_s_q && !crst_run_c) begin
          sel_d     = bus.FPGA_SEL_IN;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = sel_in_valid_c ? ST_ARM : ST_REJECT;
        end
      end
      ST_ARM: begin
        if (nss_s_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (nss_s_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
          state_d   = ST_TOUT;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REJECT, ST_TOUT: begin
        if (nss_s_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered NSS and BUSY follow the next state so they switch on the transition edge.
  always_comb begin
    nss_out_d = '1;
    if (state_d == ST_ACTIVE) begin
      nss_out_d = ~(N_CH'(1) << sel_d);
    end
    busy_d = (state_d != ST_IDLE) || (creset_d != '1);
  end

  // Combinational data path, open only in ACTIVE.
  assign route_hot_c = (state_q == ST_ACTIVE) ? (N_CH'(1) << sel_q) : '0;

  assign bus.FPGA_SPI_CLK_OUT  = {N_CH{bus.FPGA_SPI_CLK_IN}} & route_hot_c;
  assign bus.FPGA_SPI_MOSI_OUT = {N_CH{bus.FPGA_SPI_MOSI_IN}} & route_hot_c;
  assign bus.FPGA_SPI_MISO_OUT = |(bus.FPGA_SPI_MISO_IN & route_hot_c);
  assign bus.FPGA_SPI_NSS_OUT  = nss_out_q;
  assign bus.FPGA_CRESET_OUT   = creset_q;
  assign bus.FPGA_SPI_INT_OUT  = |int_s_q;
  assign bus.FPGA_CDONE_OUT    = cdone_s_q;
  assign bus.FPGA_BUSY_OUT     = busy_q;
  assign bus.FPGA_TIMEOUT_OUT  = timeout_q;

endmodule

// File: tb/tb_spi_route_ctrl.sv
// tb_spi_route_ctrl: directed, table-driven bench for spi_route_ctrl with
// N_CH=4, SEL_W=3, SETUP_CYC=4, TIMEOUT_CYC=10, CRESET_CYC=200.
module tb_spi_route_ctrl;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 3;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  spi_route_ctrl_if #(.N_CH(N_CH), .SEL_W(SEL_W)) bus ();

  spi_route_ctrl #(
    .N_CH(N_CH), .SEL_W(SEL_W), .SETUP_CYC(4), .TIMEOUT_CYC(10),
    .CRESET_CYC(200), .CNT_W(16)
  ) dut (
    .SYS_CLK_IN(clk),
    .SYS_RST_IN(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sck;
    logic       mosi;
    logic [3:0] miso;
    logic [3:0] exp_clk;
    logic [3:0] exp_mosi;
    logic       exp_miso;
  } route_vec_t;

  typedef struct {
    logic [3:0] cdone;
    logic [3:0] intr;
    logic [3:0] exp_cdone;
    logic       exp_int;
  } sync_vec_t;

  route_vec_t rv[6];
  sync_vec_t  sv[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] pattern;
    logic [7:0] rx_miso;
    logic [7:0] rx_mosi;
    logic [3:0] leak;
    logic       ok_a, ok_b, ok_c;
    logic [3:0] prev_cdone;
    logic       prev_int;

    n_vec = 0;
    n_err = 0;

    rv[0] = '{1'b1, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0};
    rv[1] = '{1'b0, 1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b1};
    rv[2] = '{1'b1, 1'b1, 4'b1011, 4'b0100, 4'b0100, 1'b0};
    rv[3] = '{1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1};
    rv[4] = '{1'b1, 1'b1, 4'b0000, 4'b0100, 4'b0100, 1'b0};
    rv[5] = '{1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1};

    sv[0] = '{4'b0101, 4'b0000, 4'b0101, 1'b0};
    sv[1] = '{4'b1010, 4'b0100, 4'b1010, 1'b1};
    sv[2] = '{4'b1111, 4'b0000, 4'b1111, 1'b0};
    sv[3] = '{4'b0000, 4'b1001, 4'b0000, 1'b1};

    rst = 1'b1;
    bus.FPGA_SPI_CLK_IN    = 1'b0;
    bus.FPGA_SPI_MOSI_IN   = 1'b0;
    bus.FPGA_SPI_NSS_IN    = 1'b1;
    bus.FPGA_SEL_IN        = '0;
    bus.FPGA_SPI_MISO_IN   = '0;
    bus.FPGA_SPI_INT_IN    = '0;
    bus.FPGA_CRESET_REQ_IN = 1'b0;
    bus.FPGA_CDONE_IN      = '0;

    // Reset state
    tick();
    tick();
    check("rst_nss_out",  32'(bus.FPGA_SPI_NSS_OUT), 32'hF);
    check("rst_creset",   32'(bus.FPGA_CRESET_OUT), 32'hF);
    check("rst_clk_out",  32'(bus.FPGA_SPI_CLK_OUT), 32'h0);
    check("rst_busy",     32'(bus.FPGA_BUSY_OUT), 32'h0);
    check("rst_timeout",  32'(bus.FPGA_TIMEOUT_OUT), 32'h0);
    rst = 1'b0;
    tick();

    // Normal transfer to channel 2: NSS_OUT low exactly at edge 7
    bus.FPGA_SEL_IN     = 3'd2;
    bus.FPGA_SPI_NSS_IN = 1'b0;
    repeat (6) tick();
    check("a_nss_edge6", 32'(bus.FPGA_SPI_NSS_OUT), 32'hF);
    check("a_clk_arm", 32'(bus.FPGA_SPI_CLK_OUT), 32'h0);
    tick();
    check("a_nss_edge7", 32'(bus.FPGA_SPI_NSS_OUT), 32'hB);
    check("a_busy", 32'(bus.FPGA_BUSY_OUT), 32'h1);

    for (int i = 0; i < 6; i++) begin
      bus.FPGA_SPI_CLK_IN  = rv[i].sck;
      bus.FPGA_SPI_MOSI_IN = rv[i].mosi;
      bus.FPGA_SPI_MISO_IN = rv[i].miso;
      #1;
      check($sformatf("route_clk[%0d]", i),  32'(bus.FPGA_SPI_CLK_OUT),  32'(rv[i].exp_clk));
      check($sformatf("route_mosi[%0d]", i), 32'(bus.FPGA_SPI_MOSI_OUT), 32'(rv[i].exp_mosi));
      check($sformatf("route_miso[%0d]", i), 32'(bus.FPGA_SPI_MISO_OUT), 32'(rv[i].exp_miso));
    end

    // 8 SCK pulses carrying 0xA5 on both MOSI and MISO[2], complement on other MISOs
    pattern = 8'hA5;
    rx_miso = '0;
    rx_mosi = '0;
    leak    = '0;
    for (int i = 7; i >= 0; i--) begin
      bus.FPGA_SPI_CLK_IN  = 1'b0;
      bus.FPGA_SPI_MOSI_IN = pattern[i];
      bus.FPGA_SPI_MISO_IN = {~pattern[i], pattern[i], ~pattern[i], ~pattern[i]};
      #1;
      rx_miso = {rx_miso[6:0], bus.FPGA_SPI_MISO_OUT};
      bus.FPGA_SPI_CLK_IN = 1'b1;
      #1;
      rx_mosi = {rx_mosi[6:0], bus.FPGA_SPI_MOSI_OUT[2]};
      leak = leak | ((bus.FPGA_SPI_CLK_OUT | bus.FPGA_SPI_MOSI_OUT) & 4'b1011);
      if (bus.FPGA_SPI_CLK_OUT[2] !== 1'b1) leak[2] = 1'b1;
    end
    bus.FPGA_SPI_CLK_IN  = 1'b0;
    bus.FPGA_SPI_MOSI_IN = 1'b0;
    check("a_miso_byte", 32'(rx_miso), 32'hA5);
    check("a_mosi_byte", 32'(rx_mosi), 32'hA5);
    check("a_leak", 32'(leak), 32'h0);

    // NSS release: NSS_OUT high on the third edge after
    bus.FPGA_SPI_NSS_IN = 1'b1;
    tick();
    tick();
    check("a_nss_hold", 32'(bus.FPGA_SPI_NSS_OUT), 32'hB);
    tick();
    check("a_nss_release", 32'(bus.FPGA_SPI_NSS_OUT), 32'hF);
    check("a_busy_idle", 32'(bus.FPGA_BUSY_OUT), 32'h0);
    check("a_timeout", 32'(bus.FPGA_TIMEOUT_OUT), 32'h0);
    tick();

    // Short NSS pulse: never reaches ACTIVE
    bus.FPGA_SEL_IN     = 3'd1;
    bus.FPGA_SPI_NSS_IN = 1'b0;
    repeat (3) tick();
    bus.FPGA_SPI_NSS_IN = 1'b1;
    ok_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.FPGA_SPI_CLK_IN = ~bus.FPGA_SPI_CLK_IN;
      tick();
      if (bus.FPGA_SPI_NSS_OUT !== 4'hF || bus.FPGA_SPI_CLK_OUT !== 4'h0) ok_a = 1'b0;
    end
    bus.FPGA_SPI_CLK_IN = 1'b0;
    check("b_no_route", 32'(ok_a), 32'h1);
    check("b_busy", 32'(bus.FPGA_BUSY_OUT), 32'h0);

    // Invalid select: REJECT; a CRESET request meanwhile is dropped
    bus.FPGA_SEL_IN      = 3'd5;
    bus.FPGA_SPI_MISO_IN = 4'hF;
    bus.FPGA_SPI_NSS_IN  = 1'b0;
    ok_a = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 5)  bus.FPGA_CRESET_REQ_IN = 1'b1;
      if (k == 10) bus.FPGA_CRESET_REQ_IN = 1'b0;
      tick();
      if (k >= 3 && bus.FPGA_BUSY_OUT !== 1'b1) ok_a = 1'b0;
      if (bus.FPGA_SPI_NSS_OUT !== 4'hF || bus.FPGA_SPI_MISO_OUT !== 1'b0) ok_a = 1'b0;
    end
    check("c_reject_quiet", 32'(ok_a), 32'h1);
    bus.FPGA_SPI_NSS_IN = 1'b1;
    tick();
    tick();
    check("c_busy_hold", 32'(bus.FPGA_BUSY_OUT), 32'h1);
    tick();
    check("c_busy_clear", 32'(bus.FPGA_BUSY_OUT), 32'h0);
    check("c_creset_dropped", 32'(bus.FPGA_CRESET_OUT), 32'hF);
    bus.FPGA_SPI_MISO_IN = 4'h0;
    tick();

    // Timeout after 10 ACTIVE cycles on channel 1
    bus.FPGA_SEL_IN     = 3'd1;
    bus.FPGA_SPI_NSS_IN = 1'b0;
    repeat (7) tick();
    check("d_nss_open", 32'(bus.FPGA_SPI_NSS_OUT), 32'hD);
    repeat (9) tick();
    check("d_nss_last", 32'(bus.FPGA_SPI_NSS_OUT), 32'hD);
    check("d_tout_pre", 32'(bus.FPGA_TIMEOUT_OUT), 32'h0);
    tick();
    check("d_nss_tout", 32'(bus.FPGA_SPI_NSS_OUT), 32'hF);
    check("d_tout_set", 32'(bus.FPGA_TIMEOUT_OUT), 32'h1);
    ok_a = 1'b1;
    for (int i = 0; i < 33; i++) begin
      bus.FPGA_SPI_CLK_IN = ~bus.FPGA_SPI_CLK_IN;
      tick();
      if (bus.FPGA_SPI_NSS_OUT !== 4'hF || bus.FPGA_SPI_CLK_OUT !== 4'h0 ||
          bus.FPGA_TIMEOUT_OUT !== 1'b1 || bus.FPGA_BUSY_OUT !== 1'b1) ok_a = 1'b0;
    end
    bus.FPGA_SPI_CLK_IN = 1'b0;
    check("d_tout_hold", 32'(ok_a), 32'h1);
    bus.FPGA_SPI_NSS_IN = 1'b1;
    repeat (4) tick();
    check("d_tout_sticky", 32'(bus.FPGA_TIMEOUT_OUT), 32'h1);
    check("d_busy_idle", 32'(bus.FPGA_BUSY_OUT), 32'h0);
    bus.FPGA_SPI_NSS_IN = 1'b0;
    tick();
    tick();
    check("d_tout_before_clr", 32'(bus.FPGA_TIMEOUT_OUT), 32'h1);
    tick();
    check("d_tout_clr", 32'(bus.FPGA_TIMEOUT_OUT), 32'h0);
    bus.FPGA_SPI_NSS_IN = 1'b1;
    repeat (5) tick();

    // CRESET on channel 1: 200-cycle pulse, NSS held off, repeat ignored
    bus.FPGA_SEL_IN        = 3'd1;
    bus.FPGA_CRESET_REQ_IN = 1'b1;
    tick();
    tick();
    check("e_creset_pre", 32'(bus.FPGA_CRESET_OUT), 32'hF);
    tick();
    check("e_creset_start", 32'(bus.FPGA_CRESET_OUT), 32'hD);
    bus.FPGA_CRESET_REQ_IN = 1'b0;
    ok_a = 1'b1;
    ok_b = 1'b1;
    ok_c = 1'b1;
    for (int k = 1; k <= 199; k++) begin
      if (k == 20) begin
        bus.FPGA_SEL_IN        = 3'd3;
        bus.FPGA_CRESET_REQ_IN = 1'b1;
      end
      if (k == 26) begin
        bus.FPGA_SEL_IN        = 3'd1;
        bus.FPGA_CRESET_REQ_IN = 1'b0;
      end
      if (k == 50) bus.FPGA_SPI_NSS_IN = 1'b0;
      tick();
      if (bus.FPGA_CRESET_OUT !== 4'hD) ok_a = 1'b0;
      if (bus.FPGA_SPI_NSS_OUT !== 4'hF) ok_b = 1'b0;
      if (bus.FPGA_BUSY_OUT !== 1'b1) ok_c = 1'b0;
    end
    check("e_creset_len", 32'(ok_a), 32'h1);
    check("e_nss_held_off", 32'(ok_b), 32'h1);
    check("e_busy_pulse", 32'(ok_c), 32'h1);
    tick();
    check("e_creset_end", 32'(bus.FPGA_CRESET_OUT), 32'hF);
    ok_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.FPGA_SPI_NSS_OUT !== 4'hF) ok_a = 1'b0;
    end
    check("e_setup_after_pulse", 32'(ok_a), 32'h1);
    tick();
    check("e_nss_open", 32'(bus.FPGA_SPI_NSS_OUT), 32'hD);
    bus.FPGA_SPI_NSS_IN = 1'b1;
    repeat (5) tick();
    check("e_nss_closed", 32'(bus.FPGA_SPI_NSS_OUT), 32'hF);

    // Asynchronous reset in the middle of ACTIVE
    bus.FPGA_SEL_IN     = 3'd0;
    bus.FPGA_SPI_NSS_IN = 1'b0;
    repeat (7) tick();
    check("f_nss_open", 32'(bus.FPGA_SPI_NSS_OUT), 32'hE);
    bus.FPGA_SPI_CLK_IN = 1'b1;
    #1;
    check("f_clk_route", 32'(bus.FPGA_SPI_CLK_OUT), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("f_rst_nss", 32'(bus.FPGA_SPI_NSS_OUT), 32'hF);
    check("f_rst_clk", 32'(bus.FPGA_SPI_CLK_OUT), 32'h0);
    check("f_rst_busy", 32'(bus.FPGA_BUSY_OUT), 32'h0);
    #10;
    bus.FPGA_SPI_CLK_IN = 1'b0;
    bus.FPGA_SPI_NSS_IN = 1'b1;
    rst = 1'b0;
    repeat (3) tick();

    // CDONE / INT synchronisation: exactly two edges of latency
    prev_cdone = 4'h0;
    prev_int   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.FPGA_CDONE_IN   = sv[i].cdone;
      bus.FPGA_SPI_INT_IN = sv[i].intr;
      tick();
      check($sformatf("sync_cdone_1[%0d]", i), 32'(bus.FPGA_CDONE_OUT), 32'(prev_cdone));
      check($sformatf("sync_int_1[%0d]", i),   32'(bus.FPGA_SPI_INT_OUT), 32'(prev_int));
      tick();
      check($sformatf("sync_cdone_2[%0d]", i), 32'(bus.FPGA_CDONE_OUT), 32'(sv[i].exp_cdone));
      check($sformatf("sync_int_2[%0d]", i),   32'(bus.FPGA_SPI_INT_OUT), 32'(sv[i].exp_int));
      prev_cdone = sv[i].exp_cdone;
      prev_int   = sv[i].exp_int;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
